// File: rtl/data_bridge_if.sv
// CPU data-port and data-memory signal bundle seen by the data bridge.
// The master side is the CPU/memory environment; the slave side is the bridge.
interface data_bridge_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_rdata;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_byteen;
  logic [31:0] dm_rdata;

  modport master (
    output cpu_addr, cpu_wdata, cpu_byteen, dm_rdata,
    input  cpu_rdata, dm_addr, dm_wdata, dm_byteen
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_byteen, dm_rdata,
    output cpu_rdata, dm_addr, dm_wdata, dm_byteen
  );
endinterface

// File: rtl/data_bridge.sv
// M-stage data bridge: decodes CPU accesses to data memory or one of two
// memory-mapped countdown timers, returns read data in the same cycle.
module data_bridge #(
  parameter logic [31:0] DM_LIMIT = 32'h0000_2FFF,
  parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7F10
) (
  input  logic         clk,
  input  logic         reset,
  data_bridge_if.slave bus,
  output logic         irq_tc0,
  output logic         irq_tc1
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  logic             sel_dm_s;
  logic [1:0]       sel_tc_s;
  logic [1:0]       irq_s;
  logic [1:0][31:0] tc_rdata_s;

  assign sel_dm_s       = (bus.cpu_addr <= DM_LIMIT);
  assign bus.dm_addr    = bus.cpu_addr;
  assign bus.dm_wdata   = bus.cpu_wdata;
  assign bus.dm_byteen  = sel_dm_s ? bus.cpu_byteen : 4'b0000;

  // Read-data return mux, unmapped addresses read as zero
  always_comb begin
    bus.cpu_rdata = 32'd0;
    if (sel_dm_s) begin
      bus.cpu_rdata = bus.dm_rdata;
    end else if (sel_tc_s[0]) begin
      bus.cpu_rdata = tc_rdata_s[0];
    end else if (sel_tc_s[1]) begin
      bus.cpu_rdata = tc_rdata_s[1];
    end else begin
      bus.cpu_rdata = 32'd0;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_tc
    localparam logic [31:0] BASE = (ch == 0) ? TC0_BASE : TC1_BASE;

    tc_state_e   state_r;
    tc_state_e   state_nxt_s;
    logic [3:0]  ctrl_r;
    logic [3:0]  ctrl_nxt_s;
    logic [3:0]  fsm_ctrl_s;
    logic [31:0] preset_r;
    logic [31:0] preset_nxt_s;
    logic [31:0] count_r;
    logic [31:0] count_nxt_s;
    logic        flag_r;
    logic        flag_nxt_s;
    logic        fsm_flag_s;
    logic        irq_r;
    logic        wr_full_s;
    logic        wr_ctrl_s;
    logic        wr_preset_s;
    logic        auto_reload_s;

    assign sel_tc_s[ch]  = (bus.cpu_addr >= BASE) && (bus.cpu_addr <= BASE + 32'd11);
    assign wr_full_s     = sel_tc_s[ch] && (bus.cpu_byteen == 4'b1111);
    assign wr_ctrl_s     = wr_full_s && (bus.cpu_addr[3:2] == 2'd0);
    assign wr_preset_s   = wr_full_s && (bus.cpu_addr[3:2] == 2'd1);
    assign auto_reload_s = (ctrl_r[2:1] == 2'b01);
    assign irq_s[ch]     = irq_r;

    assign tc_rdata_s[ch] = (bus.cpu_addr[3:2] == 2'd0) ? {28'd0, ctrl_r} :
                            (bus.cpu_addr[3:2] == 2'd1) ? preset_r :
                            (bus.cpu_addr[3:2] == 2'd2) ? count_r  : 32'd0;

    // Countdown FSM: next state, count and timer-side CTRL/flag updates
    always_comb begin
      state_nxt_s = state_r;
      count_nxt_s = count_r;
      fsm_ctrl_s  = ctrl_r;
      fsm_flag_s  = flag_r;
      case (state_r)
        ST_IDLE: begin
          if (ctrl_r[0]) begin
            state_nxt_s = ST_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          count_nxt_s = preset_r;
          state_nxt_s = ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl_r[0]) begin
            state_nxt_s = ST_IDLE;
          end else if (count_r > 32'd1) begin
            count_nxt_s = count_r - 32'd1;
          end else begin
            count_nxt_s = 32'd0;
            fsm_flag_s  = 1'b1;
            state_nxt_s = ST_INT;
          end
        end
        ST_INT: begin
          // Auto-reload leaves EN set so the next pass reloads; one-shot stops
          if (auto_reload_s) begin
            fsm_flag_s = 1'b0;
          end else begin
            fsm_ctrl_s = {ctrl_r[3:1], 1'b0};
          end
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end

    // CPU register writes override the timer's own CTRL/flag updates
    always_comb begin
      ctrl_nxt_s   = fsm_ctrl_s;
      flag_nxt_s   = fsm_flag_s;
      preset_nxt_s = preset_r;
      if (wr_ctrl_s) begin
        ctrl_nxt_s = bus.cpu_wdata[3:0];
        flag_nxt_s = 1'b0;
      end else begin
        ctrl_nxt_s = fsm_ctrl_s;
        flag_nxt_s = fsm_flag_s;
      end
      if (wr_preset_s) begin
        preset_nxt_s = bus.cpu_wdata;
      end else begin
        preset_nxt_s = preset_r;
      end
    end

    // Timer state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
      if (!reset) begin
        state_r  <= ST_IDLE;
        ctrl_r   <= 4'd0;
        preset_r <= 32'd0;
        count_r  <= 32'd0;
        flag_r   <= 1'b0;
        irq_r    <= 1'b0;
      end else begin
        state_r  <= state_nxt_s;
        ctrl_r   <= ctrl_nxt_s;
        preset_r <= preset_nxt_s;
        count_r  <= count_nxt_s;
        flag_r   <= flag_nxt_s;
        irq_r    <= ctrl_nxt_s[3] & flag_nxt_s;
      end
    end
  end

  assign irq_tc0 = irq_s[0];
  assign irq_tc1 = irq_s[1];

endmodule

// File: tb/tb_data_bridge.sv
// Self-checking bench for data_bridge: directed scenarios with literal
// expectations, then randomized traffic against a behavioural timer model.
module tb_data_bridge;
  localparam logic [31:0] DM_LIMIT = 32'h0000_2FFF;
  localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TC1_BASE = 32'h0000_7F10;

  localparam int PH_STOPPED = 0;
  localparam int PH_ARMING  = 1;
  localparam int PH_RUNNING = 2;
  localparam int PH_EXPIRED = 3;

  logic clk = 1'b0;
  logic reset;
  logic irq_tc0;
  logic irq_tc1;

  data_bridge_if bus();

  data_bridge dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .irq_tc0 (irq_tc0),
    .irq_tc1 (irq_tc1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [3:0]  m_ctrl   [2];
  logic [31:0] m_preset [2];
  logic [31:0] m_count  [2];
  logic        m_flag   [2];
  logic        m_irq    [2];
  int          m_phase  [2];
  bit          started = 1'b0;

  function automatic logic [31:0] base_of(int c);
    return (c == 0) ? TC0_BASE : TC1_BASE;
  endfunction

  function automatic int chan_of(logic [31:0] a);
    for (int c = 0; c < 2; c++)
      if (a >= base_of(c) && a <= base_of(c) + 32'd11) return c;
    return -1;
  endfunction

  function automatic logic [31:0] exp_rdata(logic [31:0] a, logic [31:0] dmr);
    int c;
    c = chan_of(a);
    if (a <= DM_LIMIT) return dmr;
    if (c < 0) return 32'd0;
    case (a[3:2])
      2'd0:    return {28'd0, m_ctrl[c]};
      2'd1:    return m_preset[c];
      default: return m_count[c];
    endcase
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin : step
      logic [3:0]  c;
      logic [31:0] p;
      logic [31:0] n;
      logic        f;
      int          ph;
      c = m_ctrl[k]; p = m_preset[k]; n = m_count[k]; f = m_flag[k]; ph = m_phase[k];
      if (ph == PH_STOPPED) begin
        if (c[0]) ph = PH_ARMING;
      end else if (ph == PH_ARMING) begin
        n = p; ph = PH_RUNNING;
      end else if (ph == PH_RUNNING) begin
        if (!c[0]) ph = PH_STOPPED;
        else if (n > 32'd1) n = n - 32'd1;
        else begin n = 32'd0; f = 1'b1; ph = PH_EXPIRED; end
      end else begin
        if (c[2:1] == 2'b01) f = 1'b0;
        else c[0] = 1'b0;
        ph = PH_STOPPED;
      end
      if (chan_of(bus.cpu_addr) == k && bus.cpu_byteen == 4'hF) begin
        if (bus.cpu_addr[3:2] == 2'd0) begin c = bus.cpu_wdata[3:0]; f = 1'b0; end
        if (bus.cpu_addr[3:2] == 2'd1) p = bus.cpu_wdata;
      end
      if (!reset) begin
        c = 4'd0; p = 32'd0; n = 32'd0; f = 1'b0; ph = PH_STOPPED;
      end
      m_ctrl[k]   <= c;
      m_preset[k] <= p;
      m_count[k]  <= n;
      m_flag[k]   <= f;
      m_phase[k]  <= ph;
      m_irq[k]    <= c[3] & f;
    end
    started <= 1'b1;
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      chk("cpu_rdata", bus.cpu_rdata, exp_rdata(bus.cpu_addr, bus.dm_rdata));
      chk("dm_byteen", {28'd0, bus.dm_byteen},
          (bus.cpu_addr <= DM_LIMIT) ? {28'd0, bus.cpu_byteen} : 32'd0);
      chk("dm_addr", bus.dm_addr, bus.cpu_addr);
      chk("dm_wdata", bus.dm_wdata, bus.cpu_wdata);
      chk("irq_tc0", {31'd0, irq_tc0}, {31'd0, m_irq[0]});
      chk("irq_tc1", {31'd0, irq_tc1}, {31'd0, m_irq[1]});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(logic [31:0] a, logic [31:0] wd, logic [3:0] be, logic [31:0] dmr);
    bus.cpu_addr   = a;
    bus.cpu_wdata  = wd;
    bus.cpu_byteen = be;
    bus.dm_rdata   = dmr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] wd);
    drive(a, wd, 4'hF, 32'd0);
    tick();
  endtask

  task automatic rd_chk(string name, logic [31:0] a, logic [31:0] e);
    drive(a, 32'd0, 4'h0, 32'd0);
    #1;
    chk(name, bus.cpu_rdata, e);
  endtask

  int os_cnt [4]  = '{3, 2, 1, 0};
  int ar_cnt [10] = '{2, 1, 0, 0, 0, 2, 1, 0, 0, 0};
  int ar_irq [10] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive(32'd0, 32'd0, 4'h0, 32'd0);
    tick(); tick();
    reset = 1'b1;
    chk("reset_irq0", {31'd0, irq_tc0}, 32'd0);
    chk("reset_irq1", {31'd0, irq_tc1}, 32'd0);
    rd_chk("reset_ctrl0", TC0_BASE, 32'd0);

    // DM passthrough and decode boundaries
    drive(32'h0000_0104, 32'h00AB_0000, 4'b0100, 32'd0);
    #1;
    chk("dm_pass_byteen", {28'd0, bus.dm_byteen}, 32'h4);
    chk("dm_pass_addr", bus.dm_addr, 32'h0000_0104);
    chk("dm_pass_wdata", bus.dm_wdata, 32'h00AB_0000);
    tick();
    drive(32'h0000_0104, 32'd0, 4'h0, 32'h1234_5678);
    #1 chk("dm_read", bus.cpu_rdata, 32'h1234_5678);
    drive(32'h0000_2FFF, 32'd0, 4'hF, 32'h0000_CAFE);
    #1 chk("dm_limit_byteen", {28'd0, bus.dm_byteen}, 32'hF);
    chk("dm_limit_rdata", bus.cpu_rdata, 32'h0000_CAFE);
    tick();
    drive(32'h0000_3000, 32'd0, 4'hF, 32'h0000_CAFE);
    #1 chk("past_dm_byteen", {28'd0, bus.dm_byteen}, 32'h0);
    chk("past_dm_rdata", bus.cpu_rdata, 32'd0);
    tick();
    drive(32'h0000_5000, 32'hFFFF_FFFF, 4'hF, 32'h5555_5555);
    #1 chk("unmapped_byteen", {28'd0, bus.dm_byteen}, 32'h0);
    chk("unmapped_rdata", bus.cpu_rdata, 32'd0);
    tick();
    rd_chk("tc0_gap_rdata", TC0_BASE + 32'd12, 32'd0);
    drive(TC0_BASE + 32'd4, 32'h0000_0055, 4'b0011, 32'd0);
    tick();
    rd_chk("partial_preset", TC0_BASE + 32'd4, 32'd0);

    // One-shot on TC0
    wr(TC0_BASE + 32'd4, 32'd3);
    wr(TC0_BASE, 32'h9);
    drive(TC0_BASE + 32'd8, 32'd0, 4'h0, 32'd0);
    tick();
    chk("os_count_load", bus.cpu_rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("os_count", bus.cpu_rdata, 32'(os_cnt[i]));
    end
    chk("os_irq_rise", {31'd0, irq_tc0}, 32'd1);
    tick();
    chk("os_irq_held", {31'd0, irq_tc0}, 32'd1);
    rd_chk("os_ctrl_en_clear", TC0_BASE, 32'h8);
    wr(TC0_BASE, 32'h8);
    chk("os_irq_cleared", {31'd0, irq_tc0}, 32'd0);

    // Auto-reload on TC1
    wr(TC1_BASE + 32'd4, 32'd2);
    wr(TC1_BASE, 32'hB);
    drive(TC1_BASE + 32'd8, 32'd0, 4'h0, 32'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("ar_count", bus.cpu_rdata, 32'(ar_cnt[i]));
      chk("ar_irq", {31'd0, irq_tc1}, 32'(ar_irq[i]));
    end

    // Masked expiry on TC0 while TC1 keeps running
    wr(TC0_BASE, 32'h1);
    drive(TC0_BASE + 32'd8, 32'd0, 4'h0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mask_irq0", {31'd0, irq_tc0}, 32'd0);
    end
    rd_chk("mask_count", TC0_BASE + 32'd8, 32'd0);
    rd_chk("mask_ctrl", TC0_BASE, 32'd0);
    wr(TC0_BASE, 32'h8);
    chk("mask_irq_after_im", {31'd0, irq_tc0}, 32'd0);
    tick();
    chk("mask_irq_after_im2", {31'd0, irq_tc0}, 32'd0);

    // Reset mid-count
    wr(TC0_BASE + 32'd4, 32'd10);
    wr(TC0_BASE, 32'h1);
    drive(TC0_BASE + 32'd8, 32'd0, 4'h0, 32'd0);
    for (int i = 0; i < 7; i++) tick();
    chk("rst_pre_count", bus.cpu_rdata, 32'd5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst_irq0", {31'd0, irq_tc0}, 32'd0);
    chk("rst_irq1", {31'd0, irq_tc1}, 32'd0);
    rd_chk("rst_count0", TC0_BASE + 32'd8, 32'd0);
    rd_chk("rst_ctrl0", TC0_BASE, 32'd0);
    rd_chk("rst_preset0", TC0_BASE + 32'd4, 32'd0);
    tick();
    rd_chk("rst_ctrl1", TC1_BASE, 32'd0);
    rd_chk("rst_preset1", TC1_BASE + 32'd4, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    rd_chk("rst_no_count0", TC0_BASE + 32'd8, 32'd0);
    rd_chk("rst_no_count1", TC1_BASE + 32'd8, 32'd0);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 4000; i++) begin
      int          r;
      int          ch;
      int          idx;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  be;
      r   = $urandom_range(0, 99);
      ch  = $urandom_range(0, 1);
      idx = $urandom_range(0, 2);
      wd  = $urandom;
      be  = 4'h0;
      if (r < 25) begin
        a  = 32'($urandom_range(0, 32'h2FFF));
        be = 4'($urandom);
      end else if (r < 75) begin
        a = base_of(ch) + 32'(idx * 4) + 32'($urandom_range(0, 3));
        r = $urandom_range(0, 99);
        if (idx == 0) begin
          wd = {28'd0, 4'($urandom)};
          if (r < 8) be = 4'hF;
          else if (r < 10) be = 4'($urandom);
        end else if (idx == 1) begin
          wd = 32'($urandom_range(0, 7));
          if (r < 20) be = 4'hF;
          else if (r < 25) be = 4'($urandom);
        end else begin
          if (r < 20) be = 4'hF;
        end
      end else if (r < 90) begin
        if ($urandom_range(0, 1) == 0) a = 32'h3000 + 32'($urandom_range(0, 32'h4EFF));
        else a = base_of(ch) + 32'd12 + 32'($urandom_range(0, 3));
        be = 4'($urandom);
      end else begin
        a  = $urandom;
        be = 4'($urandom);
      end
      drive(a, wd, be, $urandom);
      reset = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset = 1'b1;
    drive(32'd0, 32'd0, 4'h0, 32'd0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
